// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locked arbiter sharing one UART TX byte port
// Optional per-requester/timeout statistics counters enabled by macro TX_ARB_STATS_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDX_WIDTH      = 1,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_vld,
  input  logic                          tx_rdy,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          grant_id,
  output logic                          locked,
  output logic                          timeout_err,
  output logic [NUM_REQ*16-1:0]         stat_bytes,
  output logic [7:0]                    stat_timeouts
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      req_rdy_q, req_rdy_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    busy_q, busy_d;
  logic [IDX_WIDTH-1:0]    grant_q, grant_d;
  logic                    locked_q, locked_d;
  logic                    last_q, last_d;
  logic                    timeout_q, timeout_d;
  logic [TIMER_WIDTH-1:0]  wd_q, wd_d;

  logic [NUM_REQ-1:0]      own_mask;
  logic [NUM_REQ-1:0]      elig;
  logic                    found;
  int                      win;
  logic                    tx_done;
  logic                    wd_expire;

  assign tx_done   = (state_q == S_WAIT) && tx_rdy;
  assign wd_expire = (state_q == S_WAIT) && !tx_rdy &&
                     (wd_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Search starts one past the last grant, so grant_id doubles as the round-robin pointer.
  always_comb begin
    int idx;
    own_mask           = '0;
    own_mask[grant_q]  = 1'b1;
    elig               = locked_q ? (req_vld & own_mask) : req_vld;
    found              = 1'b0;
    win                = 0;
    idx                = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(grant_q) + off) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_rdy_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= IDX_WIDTH'(NUM_REQ - 1);
      locked_q  <= 1'b0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      req_rdy_q <= req_rdy_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      locked_q  <= locked_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (tx_rdy || wd_expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_rdy_d = '0;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    wd_d      = wd_q;
    busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (found) begin
          tx_data_d      = req_data[win*DATA_WIDTH +: DATA_WIDTH];
          last_d         = req_last[win];
          grant_d        = IDX_WIDTH'(win);
          req_rdy_d[win] = 1'b1;
        end
      end
      S_ISSUE: begin
        tx_vld_d = 1'b1;
        wd_d     = '0;
      end
      S_WAIT: begin
        wd_d = wd_q + TIMER_WIDTH'(1);
        // A completion on the expiry cycle still counts as success.
        if (tx_rdy) begin
          locked_d = !last_q;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_rdy     = req_rdy_q;
  assign tx_data     = tx_data_q;
  assign tx_vld      = tx_vld_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_q;

`ifdef TX_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_bytes_q;
  logic [7:0]            stat_tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bytes_q <= '0;
      stat_tmo_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tx_done && (int'(grant_q) == i) && (stat_bytes_q[i*16 +: 16] != 16'hFFFF))
          stat_bytes_q[i*16 +: 16] <= stat_bytes_q[i*16 +: 16] + 16'd1;
      end
      if (wd_expire && (stat_tmo_q != 8'hFF))
        stat_tmo_q <= stat_tmo_q + 8'd1;
    end
  end

  assign stat_bytes    = stat_bytes_q;
  assign stat_timeouts = stat_tmo_q;
`else
  assign stat_bytes    = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_vld;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;
  logic [0:0]  grant_id;
  logic        locked;
  logic        timeout_err;
  logic [31:0] stat_bytes;
  logic [7:0]  stat_timeouts;

  int tests  = 0;
  int failed = 0;

  uart_tx_arbiter #(
    .NUM_REQ(2), .IDX_WIDTH(1), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy),
    .grant_id(grant_id), .locked(locked), .timeout_err(timeout_err),
    .stat_bytes(stat_bytes), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_tx_vld", 32'(tx_vld), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd1);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_stat_bytes", stat_bytes, 32'd0);
    check("rst_stat_tmo", 32'(stat_timeouts), 32'd0);
  endtask

  task automatic wait_rdy(input int idx, input logic [7:0] d);
    int n = 0;
    do begin
      tick();
      n++;
    end while (req_rdy == 2'b00 && n < 20);
    check("req_rdy", 32'(req_rdy), 32'(1 << idx));
    check("grant_id", 32'(grant_id), 32'(idx));
    check("tx_data", 32'(tx_data), 32'(d));
    check("busy_on_grant", 32'(busy), 32'd1);
  endtask

  task automatic complete(input int dly, input logic exp_lock);
    tick();
    check("tx_vld_pulse", 32'(tx_vld), 32'd1);
    check("req_rdy_drop", 32'(req_rdy), 32'd0);
    repeat (dly) tick();
    if (dly > 0) check("tx_vld_low", 32'(tx_vld), 32'd0);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check("locked_after", 32'(locked), 32'(exp_lock));
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic seen;
    reset = 1'b1; req_vld = '0; req_data = '0; req_last = '0; tx_rdy = 1'b0;
    tick(); tick();
    check_reset_vals();

    // single byte from requester 0
    reset = 1'b0;
    req_vld = 2'b01; req_data[7:0] = 8'h41; req_last = 2'b01;
    wait_rdy(0, 8'h41);
    req_vld = 2'b00;
    complete(9, 1'b0);

    // alternation from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    req_vld = 2'b11; req_data = {8'h60, 8'h50}; req_last = 2'b11;
    wait_rdy(0, 8'h50); req_data[7:0] = 8'h51;  complete(2, 1'b0);
    wait_rdy(1, 8'h60); req_data[15:8] = 8'h61; complete(2, 1'b0);
    wait_rdy(0, 8'h51); req_vld[0] = 1'b0;      complete(2, 1'b0);
    wait_rdy(1, 8'h61); req_vld[1] = 1'b0;      complete(2, 1'b0);

    // 3-byte frame from req0 holds off req1
    req_vld = 2'b11; req_data = {8'hA0, 8'h10}; req_last = 2'b10;
    wait_rdy(0, 8'h10); req_data[7:0] = 8'h11; complete(3, 1'b1);
    wait_rdy(0, 8'h11); req_data[7:0] = 8'h12; req_last[0] = 1'b1; complete(3, 1'b1);
    wait_rdy(0, 8'h12); req_vld[0] = 1'b0; complete(3, 1'b0);
    wait_rdy(1, 8'hA0); req_vld[1] = 1'b0; complete(3, 1'b0);

    // watchdog: open a frame, then never complete the next byte
    req_vld = 2'b01; req_data[7:0] = 8'h76; req_last = 2'b00;
    wait_rdy(0, 8'h76); req_data[7:0] = 8'h77; complete(2, 1'b1);
    wait_rdy(0, 8'h77); req_vld = 2'b00;
    tick();
    check("tmo_tx_vld", 32'(tx_vld), 32'd1);
    seen = 1'b0;
    repeat (15) begin tick(); seen = seen | timeout_err; end
    check("tmo_not_early", 32'(seen), 32'd0);
    tick();
    check("tmo_pulse", 32'(timeout_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_unlock", 32'(locked), 32'd0);
`ifdef TX_ARB_STATS_EN
    check("tmo_stat", 32'(stat_timeouts), 32'd1);
`else
    check("tmo_stat", 32'(stat_timeouts), 32'd0);
`endif
    tick();
    check("tmo_one_cycle", 32'(timeout_err), 32'd0);

    // tx_rdy on the expiry cycle wins
    req_vld = 2'b10; req_data[15:8] = 8'h88; req_last = 2'b10;
    wait_rdy(1, 8'h88); req_vld = 2'b00;
    tick();
    check("coin_tx_vld", 32'(tx_vld), 32'd1);
    repeat (15) tick();
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    check("coin_no_tmo", 32'(timeout_err), 32'd0);
    check("coin_busy", 32'(busy), 32'd0);
`ifdef TX_ARB_STATS_EN
    check("coin_stat_bytes", stat_bytes, {16'd4, 16'd6});
`else
    check("coin_stat_bytes", stat_bytes, 32'd0);
`endif

    // spurious tx_rdy while idle
    tx_rdy = 1'b1; tick(); tx_rdy = 1'b0; tick();
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_tmo", 32'(timeout_err), 32'd0);
    check("spur_grant", 32'(grant_id), 32'd1);
    check("spur_tx_vld", 32'(tx_vld), 32'd0);
`ifdef TX_ARB_STATS_EN
    check("spur_stat_bytes", stat_bytes, {16'd4, 16'd6});
`else
    check("spur_stat_bytes", stat_bytes, 32'd0);
`endif

    // reset mid-frame while in WAIT
    req_vld = 2'b11; req_data = {8'hB0, 8'h90}; req_last = 2'b10;
    wait_rdy(0, 8'h90); req_data[7:0] = 8'h91; complete(2, 1'b1);
    wait_rdy(0, 8'h91); req_data[7:0] = 8'h92; req_last[0] = 1'b1;
    tick();
    check("mid_tx_vld", 32'(tx_vld), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals();
    reset = 1'b0;
    wait_rdy(0, 8'h92); req_vld[0] = 1'b0; complete(1, 1'b0);
    wait_rdy(1, 8'hB0); req_vld[1] = 1'b0; complete(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
